// File: rtl/pmem_line_adapter.sv
`default_nettype none
// ============================================================================
// Module      : pmem_line_adapter
// Description : Converts single-cycle cache line requests (fill / write-back)
//               into fixed-length memory bursts of BURST_LEN beats, each
//               BEAT_W bits wide. Beat 0 is the least-significant slice of
//               the line. Outputs are decoded from registered state, so
//               every output is zero while rst is low.
//               Optional feature macro: LINE_ADAPTER_ERR_EN adds the sticky
//               err_o flag (memory strobe seen outside a burst).
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_line_adapter #(
  parameter int BURST_LEN = 4,
  parameter int BEAT_W    = 64,
  localparam int LINE_W   = BURST_LEN * BEAT_W
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  // cache side
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  // memory side
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  input  logic              resp_i
`ifdef LINE_ADAPTER_ERR_EN
  ,
  output logic              err_o
`endif
);

  // Beat counter width; a single-beat line still needs a 1-bit index.
  localparam int K_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(BURST_LEN - 1);
  // Line addresses are aligned to 32 bytes; low five bits are forced to 0.
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFE0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                           state_q, state_d;
  logic [K_W-1:0]                   k_q, k_d;
  logic [31:0]                      addr_q, addr_d;
  logic [BURST_LEN-1:0][BEAT_W-1:0] wline_q, wline_d;
  logic [BURST_LEN-1:0][BEAT_W-1:0] line_q, line_d;

  logic w_last_beat;
  assign w_last_beat = (k_q == K_LAST);

  // Next-state and datapath updates; write wins when both requests are up.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (write_i) begin
          wline_d = line_i;
          addr_d  = address_i & ADDR_MASK;
          k_d     = '0;
          state_d = WRITE;
        end else if (read_i) begin
          addr_d  = address_i & ADDR_MASK;
          k_d     = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (resp_i) begin
          line_d[k_q] = burst_i;
          if (w_last_beat) begin
            state_d = DONE;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      WRITE: begin
        if (resp_i) begin
          if (w_last_beat) begin
            state_d = DONE;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      line_q  <= line_d;
    end
  end

  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;
  assign burst_o   = wline_q[k_q];

`ifdef LINE_ADAPTER_ERR_EN
  logic err_q, err_d;

  // Sticky flag: a memory strobe while no burst is active is a protocol error.
  always_comb begin
    err_d = err_q | (resp_i & ((state_q == IDLE) | (state_q == DONE)));
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pmem_line_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmem_line_adapter
// Description : Self-checking bench for pmem_line_adapter. Expected lines and
//               write beats are queued when a request is issued and popped
//               when the adapter presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_line_adapter;

  localparam int BL = 4;
  localparam int BW = 64;
  localparam int LW = BL * BW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   address_i = '0;
  logic          read_i = 1'b0;
  logic          write_i = 1'b0;
  logic [LW-1:0] line_i = '0;
  logic [LW-1:0] line_o;
  logic          resp_o;
  logic [31:0]   address_o;
  logic          read_o;
  logic          write_o;
  logic [BW-1:0] burst_i = '0;
  logic [BW-1:0] burst_o;
  logic          resp_i = 1'b0;
`ifdef LINE_ADAPTER_ERR_EN
  logic          err_o;
`endif

  int checks   = 0;
  int failures = 0;

  logic [LW-1:0] exp_line_q[$];
  logic [BW-1:0] exp_beat_q[$];
  logic [LW-1:0] last_read_line = '0;

  always #5 clk = ~clk;

  pmem_line_adapter #(.BURST_LEN(BL), .BEAT_W(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .resp_i    (resp_i)
`ifdef LINE_ADAPTER_ERR_EN
    ,
    .err_o     (err_o)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs a read burst that has just been accepted (adapter in READ).
  task automatic read_beats(input logic [31:0] exp_addr, input logic [LW-1:0] mem_line,
                            input logic [15:0] pat, input int plen);
    int  got;
    logic exp_resp;
    got = 0;
    exp_line_q.push_back(mem_line);
    checks++;
    if (read_o !== 1'b1 || write_o !== 1'b0) begin
      failures++;
      $display("FAIL read_start: read_o=%b write_o=%b required 1/0", read_o, write_o);
    end
    checks++;
    if (address_o !== exp_addr) begin
      failures++;
      $display("FAIL read_addr: got %h required %h", address_o, exp_addr);
    end
    for (int c = 0; c < plen; c++) begin
      resp_i = pat[c];
      if (pat[c] && got < BL) begin
        burst_i = mem_line[got*BW +: BW];
        got++;
      end else begin
        burst_i = {$urandom(), $urandom()};
      end
      address_i = $urandom();
      tick;
      resp_i = 1'b0;
      exp_resp = pat[c] && (got == BL);
      checks++;
      if (resp_o !== exp_resp) begin
        failures++;
        $display("FAIL read_resp cycle %0d: got %b required %b", c, resp_o, exp_resp);
      end
      if (!exp_resp) begin
        checks++;
        if (read_o !== 1'b1 || write_o !== 1'b0) begin
          failures++;
          $display("FAIL read_hold cycle %0d: read_o=%b write_o=%b required 1/0", c, read_o, write_o);
        end
      end
      if (resp_o === 1'b1 && exp_line_q.size() != 0) begin
        logic [LW-1:0] e;
        e = exp_line_q.pop_front();
        checks++;
        if (line_o !== e) begin
          failures++;
          $display("FAIL read_line: got %h required %h", line_o, e);
        end
        last_read_line = e;
      end
    end
    if (got == BL) begin
      checks++;
      if (exp_line_q.size() != 0) begin
        failures++;
        $display("FAIL read_no_resp: resp_o=%b required 1 after last beat", resp_o);
        exp_line_q.delete();
      end
      checks++;
      if (read_o !== 1'b0) begin
        failures++;
        $display("FAIL read_drop: read_o=%b required 0", read_o);
      end
      read_i = 1'b0;
      tick;
      checks++;
      if (resp_o !== 1'b0) begin
        failures++;
        $display("FAIL read_resp_pulse: resp_o=%b required 0", resp_o);
      end
    end
  endtask

  // Runs a write burst that has just been accepted (adapter in WRITE).
  task automatic write_beats(input logic [31:0] exp_addr, input logic [LW-1:0] wline,
                             input logic [15:0] pat, input int plen);
    int  got;
    logic exp_resp;
    got = 0;
    for (int b = 0; b < BL; b++) exp_beat_q.push_back(wline[b*BW +: BW]);
    checks++;
    if (address_o !== exp_addr) begin
      failures++;
      $display("FAIL write_addr: got %h required %h", address_o, exp_addr);
    end
    for (int c = 0; c < plen; c++) begin
      checks++;
      if (write_o !== 1'b1 || read_o !== 1'b0) begin
        failures++;
        $display("FAIL write_hold cycle %0d: write_o=%b read_o=%b required 1/0", c, write_o, read_o);
      end
      checks++;
      if (exp_beat_q.size() == 0 || burst_o !== exp_beat_q[0]) begin
        failures++;
        $display("FAIL write_beat cycle %0d: got %h required %h", c, burst_o,
                 (exp_beat_q.size() != 0) ? exp_beat_q[0] : '0);
      end
      resp_i = pat[c];
      if (pat[c] && exp_beat_q.size() != 0) begin
        void'(exp_beat_q.pop_front());
        got++;
      end
      address_i = $urandom();
      line_i    = {8{$urandom()}};
      tick;
      resp_i = 1'b0;
      exp_resp = pat[c] && (got == BL);
      checks++;
      if (resp_o !== exp_resp) begin
        failures++;
        $display("FAIL write_resp cycle %0d: got %b required %b", c, resp_o, exp_resp);
      end
    end
    if (got == BL) begin
      checks++;
      if (write_o !== 1'b0 || read_o !== 1'b0) begin
        failures++;
        $display("FAIL write_drop: write_o=%b read_o=%b required 0/0", write_o, read_o);
      end
      write_i = 1'b0;
      tick;
      checks++;
      if (resp_o !== 1'b0) begin
        failures++;
        $display("FAIL write_resp_pulse: resp_o=%b required 0", resp_o);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    checks++;
    if (line_o !== '0 || resp_o !== 1'b0 || address_o !== '0 || read_o !== 1'b0 ||
        write_o !== 1'b0 || burst_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs: line=%h resp=%b addr=%h rd=%b wr=%b burst=%h required all 0",
               line_o, resp_o, address_o, read_o, write_o, burst_o);
    end
`ifdef LINE_ADAPTER_ERR_EN
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: got %b required 0", err_o);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    tick;
    checks++;
    if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: rd=%b wr=%b resp=%b required 0/0/0", read_o, write_o, resp_o);
    end
  endtask

  task automatic test_read;
    logic [LW-1:0] l;
    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    address_i = 32'h0000_1234;
    read_i    = 1'b1;
    tick;
    read_beats(32'h0000_1220, l, 16'h000F, 4);
  endtask

  task automatic test_write;
    logic [LW-1:0] l;
    l = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    address_i = 32'hABCD_1234;
    line_i    = l;
    write_i   = 1'b1;
    tick;
    write_beats(32'hABCD_1220, l, 16'h000F, 4);
    checks++;
    if (line_o !== last_read_line) begin
      failures++;
      $display("FAIL line_hold: got %h required %h", line_o, last_read_line);
    end
  endtask

  task automatic test_stall;
    logic [LW-1:0] l;
    l = {{16{4'h8}}, {16{4'h7}}, {16{4'h6}}, {16{4'h5}}};
    address_i = 32'h0040_0010;
    read_i    = 1'b1;
    tick;
    read_beats(32'h0040_0000, l, 16'b1011001, 7);
  endtask

  task automatic test_simultaneous;
    logic [LW-1:0] wl;
    logic [LW-1:0] rl;
    wl = {{16{4'h9}}, {16{4'hF}}, {16{4'hE}}, 64'h0123_4567_89AB_CDEF};
    rl = {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
          64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};
    address_i = 32'h0000_5678;
    line_i    = wl;
    read_i    = 1'b1;
    write_i   = 1'b1;
    tick;
    checks++;
    if (write_o !== 1'b1 || read_o !== 1'b0) begin
      failures++;
      $display("FAIL simul_write_first: write_o=%b read_o=%b required 1/0", write_o, read_o);
    end
    write_beats(32'h0000_5660, wl, 16'b110101, 6);
    checks++;
    if (read_o !== 1'b0) begin
      failures++;
      $display("FAIL simul_idle_gap: read_o=%b required 0", read_o);
    end
    address_i = 32'h0000_9ABC;
    tick;
    read_beats(32'h0000_9AA0, rl, 16'h000F, 4);
  endtask

  task automatic test_idle_resp;
    logic [LW-1:0] held;
    held = line_o;
    resp_i  = 1'b1;
    burst_i = {BW{1'b1}};
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0 || line_o !== held) begin
        failures++;
        $display("FAIL idle_resp_ignored: rd=%b wr=%b resp=%b line=%h required 0/0/0 line %h",
                 read_o, write_o, resp_o, line_o, held);
      end
    end
    resp_i = 1'b0;
`ifdef LINE_ADAPTER_ERR_EN
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_set: got %b required 1", err_o);
    end
`endif
  endtask

  task automatic test_reset_mid_burst;
    logic [LW-1:0] wl;
    logic [LW-1:0] rl;
    wl = {{16{4'h6}}, {16{4'h5}}, {16{4'h4}}, {16{4'h3}}};
    rl = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
          64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    address_i = 32'h0000_0100;
    line_i    = wl;
    write_i   = 1'b1;
    tick;
    write_beats(32'h0000_0100, wl, 16'b11, 2);
    exp_beat_q.delete();
    write_i = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (line_o !== '0 || resp_o !== 1'b0 || address_o !== '0 || read_o !== 1'b0 ||
        write_o !== 1'b0 || burst_o !== '0) begin
      failures++;
      $display("FAIL midburst_reset_outputs: line=%h resp=%b addr=%h rd=%b wr=%b burst=%h required all 0",
               line_o, resp_o, address_o, read_o, write_o, burst_o);
    end
`ifdef LINE_ADAPTER_ERR_EN
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: got %b required 0", err_o);
    end
`endif
    #3;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if (resp_o !== 1'b0 || write_o !== 1'b0) begin
        failures++;
        $display("FAIL midburst_no_resp: resp=%b wr=%b required 0/0", resp_o, write_o);
      end
    end
    address_i = 32'h0000_0200;
    read_i    = 1'b1;
    tick;
    read_beats(32'h0000_0200, rl, 16'h000F, 4);
  endtask

`ifdef LINE_ADAPTER_ERR_EN
  task automatic test_err_sticky;
    logic [LW-1:0] rl;
    rl = {4{64'h5A5A_A5A5_5A5A_A5A5}};
    resp_i = 1'b1;
    tick;
    resp_i = 1'b0;
    address_i = 32'h0000_0300;
    read_i    = 1'b1;
    tick;
    read_beats(32'h0000_0300, rl, 16'h000F, 4);
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: got %b required 1", err_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_reset: got %b required 0", err_o);
    end
    #3;
    rst = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_read;
    test_write;
    test_stall;
    test_simultaneous;
    test_idle_resp;
    test_reset_mid_burst;
`ifdef LINE_ADAPTER_ERR_EN
    test_err_sticky;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pmem_line_adapter.md
PMEM_LINE_ADAPTER -- requirements
Module: pmem_line_adapter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4: number of beats per line.
REQ-002 SHALL have parameter BEAT_W, default 64: beat width in bits. Line width LINE_W = BURST_LEN*BEAT_W (256 at defaults).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 address_i  input  32  line request address from the cache.
REQ-006 read_i  input  1  cache line-fill request, held until resp_o.
REQ-007 write_i  input  1  cache write-back request, held until resp_o.
REQ-008 line_i  input  LINE_W  write-back line data.
REQ-009 line_o  output  LINE_W  assembled fill line.
REQ-010 resp_o  output  1  one-cycle completion pulse to the cache.
REQ-011 address_o  output  32  burst address to memory.
REQ-012 read_o  output  1  memory read burst request.
REQ-013 write_o  output  1  memory write burst request.
REQ-014 burst_i  input  BEAT_W  memory read beat.
REQ-015 burst_o  output  BEAT_W  memory write beat.
REQ-016 resp_i  input  1  memory beat strobe; one beat is transferred per cycle in which it is high.

Function
REQ-017 SHALL implement the FSM states IDLE, READ, WRITE and DONE.
REQ-018 IDLE: on write_i, SHALL latch line_i and {address_i[31:5],5'b0} and go to WRITE; else on read_i, SHALL latch the address and go to READ.
REQ-019 When read_i and write_i are both high in IDLE, write SHALL win; read SHALL be serviced only if read_i is still high after resp_o.
REQ-020 READ: read_o SHALL be 1 and address_o SHALL be the latched address.
REQ-021 READ: each resp_i cycle SHALL store burst_i into line_o bits [k*BEAT_W +: BEAT_W], where k is the beat counter starting at 0 (little-endian beat order).
REQ-022 WRITE: write_o SHALL be 1, address_o SHALL be the latched address, and burst_o SHALL be latched-line beat k.
REQ-023 WRITE: k SHALL advance on each resp_i cycle.
REQ-024 A resp_i gap (stall) mid-burst SHALL hold k, read_o/write_o and burst_o unchanged.
REQ-025 On the resp_i cycle with k == BURST_LEN-1, the FSM SHALL go to DONE; read_o and write_o SHALL deassert the following cycle.
REQ-026 DONE: resp_o SHALL be 1 for exactly one cycle and line_o SHALL be valid; the FSM SHALL then return to IDLE.
REQ-027 Latency: resp_o SHALL assert exactly one cycle after the last beat; minimum request-to-resp_o latency is BURST_LEN+2 cycles.
REQ-028 The beat counter SHALL be $clog2(BURST_LEN) bits and SHALL reset to 0 on each IDLE exit; it SHALL never wrap mid-burst.
REQ-029 resp_i in IDLE or DONE SHALL be ignored.
REQ-030 line_o SHALL hold its value until the next READ overwrites it.
REQ-031 Changes to address_i or line_i during a burst SHALL have no effect.
REQ-032 read_o and write_o SHALL never be high together.

Reset
REQ-033 While rst = 0, asynchronously: state = IDLE, k = 0, and all outputs (line_o, resp_o, address_o, read_o, write_o, burst_o) = 0.
REQ-034 Reset mid-burst SHALL abort the burst; no resp_o SHALL follow, and the first request after reset release SHALL start a fresh burst at beat 0.

Configuration
REQ-035 Macro LINE_ADAPTER_ERR_EN: when defined, the block SHALL add output err_o (1 bit, reset 0).
REQ-036 With LINE_ADAPTER_ERR_EN, err_o SHALL set sticky on resp_i high in IDLE or DONE, and SHALL clear only on reset.
REQ-037 Without LINE_ADAPTER_ERR_EN, the err_o port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-038 Read: read_i=1, address_i=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i -> address_o=0x0000_1220, line_o=0x44..44_33..33_22..22_11..11, resp_o pulses once exactly one cycle after the 4th beat.
REQ-039 Write: write_i=1, line_i=0xDDDD..CCCC..BBBB..AAAA (beat0 = 0xAAAA..AAAA) -> burst_o presents beats 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. in order, one per resp_i; write_o drops and resp_o pulses once.
REQ-040 Stall: read with resp_i pattern 1,0,0,1,1,0,1 -> 4 beats captured in order, resp_o pulses only after the 7th cycle.
REQ-041 Simultaneous: read_i=write_i=1 in IDLE -> write burst first, resp_o; read_i held, write_i dropped -> read burst follows.
REQ-042 Reset: rst=0 after beat 2 of a write -> all outputs 0 immediately, no resp_o; a new read then completes normally from beat 0.
REQ-043 With LINE_ADAPTER_ERR_EN: resp_i=1 in IDLE -> err_o=1 and remains 1 until rst=0.
